// File: rtl/onchip_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_arb_pkg
// Shared constants and types for the on-chip RAM arbiter.
//   ADDR_W / DATA_W / BE_W / DEPTH : geometry of the 64 x 128-bit RAM port
//   arb_state_t                    : arbiter state (CLEAR only used when
//                                    ONCHIP_MEM_ARB_CLEAR_EN is defined)
// -----------------------------------------------------------------------------
package onchip_mem_arb_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 128;
    localparam int BE_W   = 16;
    localparam int DEPTH  = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/onchip_mem_rr_pick.sv
// -----------------------------------------------------------------------------
// onchip_mem_rr_pick
// Rotate-priority picker: returns the first requester strictly after
// last_grant_i, searching cyclically upward.
// Ports:
//   req_i        in  N        request mask
//   last_grant_i in  IDX_W    index of the previous winner
//   gnt_o        out N        one-hot grant (all zero when no request)
//   gnt_idx_o    out IDX_W    index of the granted requester
//   any_o        out 1        at least one request present
// -----------------------------------------------------------------------------
module onchip_mem_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic found;
    int   j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        // Offsets 1..N visit every requester once, last winner checked last.
        for (int k = 1; k <= N; k++) begin
            j = int'(last_grant_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IDX_W'(j);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
// Round-robin arbiter sharing one port of the 64 x 128-bit RAM between
// NUM_REQ Avalon-MM style requesters. One transaction per cycle, grant decided
// combinationally, read data returned one cycle after acceptance.
//
// Optional feature: define ONCHIP_MEM_ARB_CLEAR_EN to add a CLEAR state that
// writes zero to all 64 words after reset before any requester is served.
//
// Handshake: a requester's transfer is accepted in a cycle where its read or
// write is high and its req_waitrequest bit is low; requests must be held
// while waitrequest is high. req_readdatavalid is a one-hot pulse, one cycle
// after an accepted read, qualifying the broadcast req_readdata.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_address/read/write/byteenable/writedata   packed per-requester inputs
//   req_waitrequest  out NUM_REQ       stall per requester
//   req_readdata     out 128           RAM q passed straight through
//   req_readdatavalid out NUM_REQ      owner of req_readdata
//   mem_*                              to the RAM port (mem_readdata from it)
//   dbg_state_o      out 1             current state (0 = CLEAR, 1 = RUN)
//   dbg_last_grant_o out IDX           index of the most recent winner
// -----------------------------------------------------------------------------
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*BE_W-1:0]       req_byteenable,
    input  logic [NUM_REQ*DATA_W-1:0]     req_writedata,
    output logic [NUM_REQ-1:0]            req_waitrequest,
    output logic [DATA_W-1:0]             req_readdata,
    output logic [NUM_REQ-1:0]            req_readdatavalid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [BE_W-1:0]               mem_byteenable,
    output logic [DATA_W-1:0]             mem_writedata,
    input  logic [DATA_W-1:0]             mem_readdata,
    output logic                          dbg_state_o,
    output logic [$clog2(NUM_REQ)-1:0]    dbg_last_grant_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t           state;
    logic [NUM_REQ-1:0]   active;
    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 any_req;
    logic                 run_ok;
    logic                 grant_valid;
    logic                 gnt_is_write;
    logic [IDX_W-1:0]     last_grant_q;
    logic [NUM_REQ-1:0]   rd_pend_q;
    logic [NUM_REQ-1:0]   rd_pend_d;

`ifdef ONCHIP_MEM_ARB_CLEAR_EN
    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [ADDR_W-1:0]    clr_cnt_q;
    logic [ADDR_W-1:0]    clr_cnt_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: one word per cycle, leave CLEAR after the last address.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end
    end

    assign state = state_q;
`else
    assign state = RUN;
`endif

    assign dbg_state_o      = logic'(state);
    assign dbg_last_grant_o = last_grant_q;

    assign active = req_read | req_write;
    assign run_ok = (state == RUN) && !reset;

    onchip_mem_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i        (active),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx),
        .any_o        (any_req)
    );

    assign grant_valid  = run_ok && any_req;
    // Read and write together counts as a write.
    assign gnt_is_write = |(gnt & req_write);

    // Output logic: RAM port mux and requester stalls.
    always_comb begin
        mem_address     = req_address[ADDR_W-1:0];
        mem_byteenable  = req_byteenable[BE_W-1:0];
        mem_writedata   = req_writedata[DATA_W-1:0];
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        req_waitrequest = '1;

`ifdef ONCHIP_MEM_ARB_CLEAR_EN
        if (state == CLEAR && !reset) begin
            mem_address    = clr_cnt_q;
            mem_byteenable = '1;
            mem_writedata  = '0;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
        end
`endif
        if (run_ok) begin
            req_waitrequest = active & ~gnt;
        end
        if (grant_valid) begin
            mem_chipselect = 1'b1;
            mem_write      = gnt_is_write;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    mem_address    = req_address[i*ADDR_W +: ADDR_W];
                    mem_byteenable = req_byteenable[i*BE_W +: BE_W];
                    mem_writedata  = req_writedata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign rd_pend_d = (grant_valid && !gnt_is_write) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q    <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            rd_pend_q <= rd_pend_d;
            if (grant_valid) begin
                last_grant_q <= gnt_idx;
            end
        end
    end

    // A read in flight when reset rises is dropped, not delivered.
    assign req_readdatavalid = reset ? '0 : rd_pend_q;
    assign req_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;

  localparam int NR = 3;
  localparam int IW = 2;
  localparam int CW = 130;

  logic              clk;
  logic              reset;
  logic [NR*6-1:0]   req_address;
  logic [NR-1:0]     req_read;
  logic [NR-1:0]     req_write;
  logic [NR*16-1:0]  req_byteenable;
  logic [NR*128-1:0] req_writedata;
  logic [NR-1:0]     req_waitrequest;
  logic [127:0]      req_readdata;
  logic [NR-1:0]     req_readdatavalid;
  logic [5:0]        mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [15:0]       mem_byteenable;
  logic [127:0]      mem_writedata;
  logic [127:0]      mem_readdata;
  logic              dbg_state_o;
  logic [IW-1:0]     dbg_last_grant_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] ram [64];
  logic [5:0]   ram_addr_q;
  logic [127:0] ref_mem [64];
  logic [CW-1:0] exp_q[$];

  onchip_mem_arbiter #(.NUM_REQ(NR)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_address       (req_address),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_byteenable    (req_byteenable),
    .req_writedata     (req_writedata),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .mem_address       (mem_address),
    .mem_chipselect    (mem_chipselect),
    .mem_write         (mem_write),
    .mem_byteenable    (mem_byteenable),
    .mem_writedata     (mem_writedata),
    .mem_readdata      (mem_readdata),
    .dbg_state_o       (dbg_state_o),
    .dbg_last_grant_o  (dbg_last_grant_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model (registered address, unregistered q) ----------------
  function automatic logic [127:0] init_word(input int a);
    logic [127:0] w;
    for (int b = 0; b < 16; b++) w[8*b +: 8] = 8'(a * 7 + b + 1);
    return w;
  endfunction

  initial begin
    for (int a = 0; a < 64; a++) begin
      ram[a]     = init_word(a);
      ref_mem[a] = init_word(a);
    end
    ram_addr_q = '0;
  end

  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 16; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [NR-1:0] acc;
    logic [NR-1:0] own;
    logic [CW-1:0] e;
    logic [5:0]    a;
    logic [15:0]   be;
    logic [127:0]  wd;
    if (reset) begin
      check("rst_rdv", CW'(req_readdatavalid), CW'(0));
      exp_q.delete();
    end else begin
      if (req_readdatavalid != '0) begin
        if (exp_q.size() == 0) begin
          check("rdv_unexpected", CW'(req_readdatavalid), CW'(0));
        end else begin
          e = exp_q.pop_front();
          own = '0;
          own[e[129:128]] = 1'b1;
          check("rdv_owner", CW'(req_readdatavalid), CW'(own));
          check("rdata", CW'(req_readdata), CW'(e[127:0]));
        end
      end
      acc = (req_read | req_write) & ~req_waitrequest;
      if (acc != '0) check("one_accept", CW'($countones(acc)), CW'(1));
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          a  = req_address[i*6 +: 6];
          be = req_byteenable[i*16 +: 16];
          wd = req_writedata[i*128 +: 128];
          check("mem_cs", CW'(mem_chipselect), CW'(1));
          check("mem_addr", CW'(mem_address), CW'(a));
          if (req_write[i]) begin
            check("mem_we", CW'(mem_write), CW'(1));
            check("mem_be", CW'(mem_byteenable), CW'(be));
            check("mem_wd", CW'(mem_writedata), CW'(wd));
            for (int b = 0; b < 16; b++)
              if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
          end else begin
            check("mem_rd", CW'(mem_write), CW'(0));
            exp_q.push_back({2'(i), ref_mem[a]});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr, input logic [5:0] a,
                         input logic [15:0] be, input logic [127:0] wd);
    req_read[i]                 = rd;
    req_write[i]                = wr;
    req_address[i*6 +: 6]       = a;
    req_byteenable[i*16 +: 16]  = be;
    req_writedata[i*128 +: 128] = wd;
  endtask

  task automatic idle_all();
    req_read  = '0;
    req_write = '0;
  endtask

  task automatic gen_req(input int i, input bit all_read);
    int op;
    op = all_read ? 1 : $urandom_range(0, 3);
    set_req(i, (op == 1) || (op == 3), (op == 2) || (op == 3),
            6'($urandom_range(0, 7)), 16'($urandom), {$urandom, $urandom, $urandom, $urandom});
  endtask

  // Requests are held until accepted; all_read checks the rotation order.
  task automatic run_traffic(input int ncyc, input bit all_read, input int first_id);
    int exp_id;
    logic [NR-1:0] acc;
    exp_id = first_id;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < NR; i++)
        if (!(req_read[i] | req_write[i])) gen_req(i, all_read);
      @(negedge clk);
      acc = (req_read | req_write) & ~req_waitrequest;
      if (all_read) begin
        check("rr_order", CW'(acc), CW'(1 << exp_id));
        exp_id = (exp_id + 1) % NR;
      end
      next_cycle();
      for (int i = 0; i < NR; i++)
        if (acc[i]) begin
          req_read[i]  = 1'b0;
          req_write[i] = 1'b0;
        end
    end
    idle_all();
    repeat (2) next_cycle();
  endtask

  task automatic clear_phase();
`ifdef ONCHIP_MEM_ARB_CLEAR_EN
    for (int a = 0; a < 64; a++) ref_mem[a] = '0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("clr_cs", CW'(mem_chipselect), CW'(1));
      check("clr_we", CW'(mem_write), CW'(1));
      check("clr_addr", CW'(mem_address), CW'(k));
      check("clr_wait", CW'(req_waitrequest), CW'({NR{1'b1}}));
      next_cycle();
    end
    @(negedge clk);
    check("clr_done_state", CW'(dbg_state_o), CW'(1));
`endif
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] w;

  initial begin
    reset          = 1'b1;
    req_address    = '0;
    req_read       = '0;
    req_write      = '0;
    req_byteenable = '0;
    req_writedata  = '0;
    set_req(0, 1, 0, 6'd5, 16'hFFFF, '0);

    // Reset state: requests stalled, RAM port idle.
    repeat (3) begin
      @(negedge clk);
      check("rst_wait", CW'(req_waitrequest), CW'({NR{1'b1}}));
      check("rst_cs", CW'(mem_chipselect), CW'(0));
      check("rst_we", CW'(mem_write), CW'(0));
      next_cycle();
    end
    reset = 1'b0;

`ifdef ONCHIP_MEM_ARB_CLEAR_EN
    // req0 read of address 5 held through the clear sequence.
    clear_phase();
    check("first_run_wait", CW'(req_waitrequest[0]), CW'(0));
    next_cycle();
    idle_all();
    @(negedge clk);
    check("clr_read_zero", CW'(req_readdata), CW'(0));
    next_cycle();
`else
    idle_all();
`endif

    // Partial write then next-cycle read of address 10.
    set_req(0, 0, 1, 6'd10, 16'h000F, {16{8'hA5}});
    @(negedge clk);
    check("wr_zero_wait", CW'(req_waitrequest), CW'(0));
    check("wr_mem_addr", CW'(mem_address), CW'(10));
    next_cycle();
    set_req(0, 1, 0, 6'd10, 16'hFFFF, '0);
    next_cycle();
    idle_all();
    @(negedge clk);
    check("raw_rdv", CW'(req_readdatavalid), CW'(3'b001));
    check("raw_low", CW'(req_readdata[31:0]), CW'(32'hA5A5A5A5));
`ifndef ONCHIP_MEM_ARB_CLEAR_EN
    w = init_word(10);
    check("raw_high", CW'(req_readdata[127:32]), CW'(w[127:32]));
`endif
    next_cycle();

    // req1 alone: zero wait, then req0 wins contention against req1.
    set_req(1, 1, 0, 6'd3, 16'hFFFF, '0);
    @(negedge clk);
    check("solo_wait", CW'(req_waitrequest), CW'(0));
    next_cycle();
    idle_all();
    @(negedge clk);
    check("solo_last", CW'(dbg_last_grant_o), CW'(1));
    next_cycle();
    set_req(0, 1, 0, 6'd2, 16'hFFFF, '0);
    set_req(1, 1, 0, 6'd4, 16'hFFFF, '0);
    @(negedge clk);
    check("contend_wait", CW'(req_waitrequest), CW'(3'b010));
    next_cycle();
    req_read[0] = 1'b0;
    @(negedge clk);
    check("contend_second", CW'(req_waitrequest), CW'(0));
    next_cycle();
    idle_all();

    // All three reading continuously: rotation 2,0,1,...
    run_traffic(12, 1'b1, 2);

    // Read and write together on req1 is a write without readdatavalid.
    set_req(1, 1, 1, 6'd7, 16'hFFFF, {4{32'hDEADBEEF}});
    @(negedge clk);
    check("rw_we", CW'(mem_write), CW'(1));
    check("rw_wait", CW'(req_waitrequest[1]), CW'(0));
    next_cycle();
    set_req(1, 1, 0, 6'd7, 16'hFFFF, '0);
    @(negedge clk);
    check("rw_no_rdv", CW'(req_readdatavalid), CW'(0));
    next_cycle();
    idle_all();
    @(negedge clk);
    check("rw_readback", CW'(req_readdata), CW'({4{32'hDEADBEEF}}));
    next_cycle();

    // Random mixed traffic.
    run_traffic(60, 1'b0, 0);

    // Reset the cycle after a read is accepted: no data delivered.
    set_req(0, 1, 0, 6'd1, 16'hFFFF, '0);
    @(negedge clk);
    check("prerst_wait", CW'(req_waitrequest[0]), CW'(0));
    next_cycle();
    idle_all();
    reset = 1'b1;
    @(negedge clk);
    check("rst_drop_rdv", CW'(req_readdatavalid), CW'(0));
    next_cycle();
    @(negedge clk);
    check("rst_drop_rdv2", CW'(req_readdatavalid), CW'(0));
    next_cycle();
    reset = 1'b0;
    clear_phase();

    // Operation resumes after reset.
    set_req(0, 1, 0, 6'd10, 16'hFFFF, '0);
    next_cycle();
    idle_all();
    repeat (3) next_cycle();
    check("exp_q_empty", CW'(exp_q.size()), CW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Round-robin arbiter that shares one port of the 64 x 128-bit on-chip dual-port RAM among `NUM_REQ` Avalon-MM style requesters. It sits between the fabric-side masters (DMA, compute engines) and the RAM's second port. It issues at most one transaction per cycle and returns read data with fixed 1-cycle latency to the requester that issued the read. An optional post-reset clear sequencer zeroes the RAM before any requester is served.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters; legal range 2..4.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_address`  in  NUM_REQ*6  word address, requester i in bits [6i+5:6i].
- `req_read`  in  NUM_REQ  read request per requester.
- `req_write`  in  NUM_REQ  write request per requester.
- `req_byteenable`  in  NUM_REQ*16  byte enables.
- `req_writedata`  in  NUM_REQ*128  write data.
- `req_waitrequest`  out  NUM_REQ  stall; transfer accepted in a cycle where the request is high and this is low.
- `req_readdata`  out  128  read data, broadcast to all requesters.
- `req_readdatavalid`  out  NUM_REQ  one-hot pulse marking the owner of `req_readdata`.
- `mem_address`  out  6  to RAM port.
- `mem_chipselect`  out  1  to RAM port.
- `mem_write`  out  1  to RAM port.
- `mem_byteenable`  out  16  to RAM port.
- `mem_writedata`  out  128  to RAM port.
- `mem_readdata`  in  128  RAM output: unregistered q, address registered on clk, so read latency is 1.

## Operation
- States: `CLEAR` (only with the macro) and `RUN`. Reset enters `CLEAR` if the macro is defined, otherwise `RUN`.
- Active request for requester i is `req_read[i] | req_write[i]`. If both are high, the transfer is a write and no readdatavalid is produced.
- Grant in `RUN`:
  - The first active requester strictly after `last_grant`, searching cyclically upward.
  - `last_grant` resets to NUM_REQ-1, so requester 0 wins the first contention.
  - `last_grant` updates only in cycles with a grant.
- Memory outputs in a grant cycle:
  - `mem_*` outputs are combinational copies of the winner's signals.
  - `mem_chipselect` = 1; `mem_write` = winner is writing.
- No grant: `mem_chipselect` = 0, `mem_write` = 0, address/data don't-care (drive the requester 0 value).
- `req_waitrequest[i]` = 1 when in `CLEAR`, when `reset` is high, or when active and not granted; otherwise 0.
- Read return:
  - Registered `rd_pend` (one-hot, NUM_REQ bits) is set to the grant mask when the granted op is a read, else 0.
  - `req_readdatavalid` = `rd_pend`.
  - `req_readdata` = `mem_readdata` passed straight through.
- A write followed by a read to the same address in the next cycle returns the new data.
- `CLEAR` state:
  - A 6-bit counter drives `mem_address`, `mem_chipselect` = 1, `mem_write` = 1, `mem_byteenable` = all 1s, `mem_writedata` = 0.
  - The counter steps 0..63 and the state moves to `RUN` after writing address 63 (64 cycles total).
- Reset mid-operation clears `rd_pend`, `last_grant`, counter and state. Pending read data is discarded.

## Timing
- Reset values: `req_readdatavalid` = 0, `req_waitrequest` = all 1s, `mem_chipselect` = 0, `mem_write` = 0.
- Grant decision is combinational in the same cycle as the request: zero added cycles to the RAM address.
- Read latency: accepted in cycle T gives `req_readdatavalid` and data in T+1. Back-to-back reads from any mix of requesters sustain 1 per cycle.
- Fairness: with all NUM_REQ requesters continuously active, each is granted exactly once per NUM_REQ cycles.
- The critical path is the rotate-priority-encode into the `mem_*` muxes. No registers are on the request path.

## Configuration
- `ONCHIP_MEM_ARB_CLEAR_EN` defined: the `CLEAR` state exists. The first `RUN` grant is possible at cycle 64 after reset deassertion, and the RAM is all-zero at that point.
- Not defined: no counter and no `CLEAR` state. Grants are possible in the first cycle after reset deassertion, and RAM contents are left at their init-file values.

## Structure
- Package `onchip_mem_arb_pkg` holds:
  - Constants ADDR_W=6, DATA_W=128, BE_W=16, DEPTH=64.
  - The state enum `arb_state_t` {CLEAR, RUN}.
- Sub-module `onchip_mem_rr_pick`: a parameterized rotate-priority picker. Inputs are the request mask and `last_grant`; outputs are a one-hot grant and an index.

## Test plan
- Macro defined: deassert reset, hold req0 read active. Required: waitrequest high for 64 cycles, `mem_write` pulses to addresses 0..63, then the read of address 5 returns 0 one cycle after acceptance.
- Macro undefined: req0 writes 0xA5 repeated in all bytes to address 10 with byteenable 0x000F. The next-cycle read of address 10 returns 0xA5A5A5A5 in bits [31:0], and the other bytes keep their init values.
- NUM_REQ=3, all three reading continuously. Required: grant order 0,1,2,0,1,2…, with readdatavalid one-hot following the same order delayed by 1 cycle.
- Req1 asserts read and write together. Required: a write is performed and no readdatavalid is asserted for req1.
- Reset asserted the cycle after req0's read is accepted. Required: `req_readdatavalid` = 0 in the following cycle.
- req0 idle, req1 requests alone. Required: req1 is granted with zero wait, and `last_grant` = 1 so the next contention favors req0.
